// File: rtl/signal_router_param.sv
// signal_router_param: per-channel source select (constant, PWM, divided
// clock or external input) followed by a registered routing crossbar.
// Dividers and PWMs are clock enables in the single CLK domain. The
// configuration is double-buffered and committed atomically by CFG_LOAD.
module signal_router_param #(
  parameter  int NCH  = 8,
  parameter  int W    = 8,
  parameter  int DIVW = 26,
  parameter  int PWMW = 8,
  localparam int LW   = $clog2(NCH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH*W-1:0]    IN,
  input  logic [NCH*W-1:0]    C,
  input  logic [NCH*DIVW-1:0] DIV,
  input  logic [NCH*PWMW-1:0] DUTY,
  input  logic [NCH*2-1:0]    RSEL,
  input  logic [NCH*LW-1:0]   RLOC,
  input  logic              CFG_LOAD,
  output logic              CFG_ACK,
  output logic [NCH*W-1:0]    OUT
);

  typedef enum logic [1:0] {
    SEL_CONST = 2'b00,
    SEL_PWM   = 2'b01,
    SEL_CLOCK = 2'b10,
    SEL_INPUT = 2'b11
  } sel_e;

  // Active configuration
  sel_e            asel   [NCH];
  logic [LW-1:0]   aloc   [NCH];
  logic [DIVW-1:0] adiv   [NCH];
  logic [PWMW-1:0] aduty  [NCH];

  // Divider / PWM state
  logic [DIVW-1:0] dcnt   [NCH];
  logic [PWMW-1:0] pcnt   [NCH];
  logic [NCH-1:0]  ckb;
  logic [NCH-1:0]  pwb;
  logic [NCH-1:0]  tick;

  // Pipeline: source register and the route index aligned with it, so a
  // commit switches selection and routing on the same OUT update.
  logic [W-1:0]    src    [NCH];
  logic [LW-1:0]   aloc_d [NCH];

  // Commit shadow ports into the active configuration; acknowledge next cycle.
  always_ff @(posedge CLK) begin
    // NOTE: every register in a clocked block uses <= so all of them sample
    // pre-edge values; a blocking = here would leak new values downstream.
    if (RST) begin
      CFG_ACK <= 1'b0;
      // NOTE: these arrays are flip-flops rather than a RAM macro, so they
      // take the reset like any other register.
      for (int i = 0; i < NCH; i++) begin
        asel[i]  <= SEL_CONST;
        aloc[i]  <= '0;
        adiv[i]  <= '0;
        aduty[i] <= '0;
      end
    end else begin
      CFG_ACK <= CFG_LOAD;
      if (CFG_LOAD) begin
        for (int i = 0; i < NCH; i++) begin
          asel[i]  <= sel_e'(RSEL[i*2 +: 2]);
          aloc[i]  <= RLOC[i*LW +: LW];
          adiv[i]  <= DIV[i*DIVW +: DIVW];
          aduty[i] <= DUTY[i*PWMW +: PWMW];
        end
      end
    end
  end

  // Divider terminal count; adiv==0 never ticks, so adiv-1 cannot underflow.
  always_comb begin
    // NOTE: default first so every path assigns tick and no latch is inferred.
    tick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (adiv[i] != '0 && dcnt[i] == adiv[i] - DIVW'(1)) begin
        tick[i] = 1'b1;
      end
    end
  end

  // Divider counters, divided-clock bits and PWM counters; a commit restarts them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ckb <= '0;
      pwb <= '0;
      for (int i = 0; i < NCH; i++) begin
        dcnt[i] <= '0;
        pcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        pwb[i] <= (pcnt[i] < aduty[i]);
        if (CFG_LOAD) begin
          // A load on a tick edge wins: the tick is discarded.
          dcnt[i] <= '0;
          pcnt[i] <= '0;
          ckb[i]  <= 1'b0;
        end else if (tick[i]) begin
          dcnt[i] <= '0;
          pcnt[i] <= pcnt[i] + PWMW'(1);
          ckb[i]  <= ~ckb[i];
        end else if (adiv[i] != '0) begin
          dcnt[i] <= dcnt[i] + DIVW'(1);
        end else begin
          dcnt[i] <= '0;
        end
      end
    end
  end

  // Source stage: pick each channel's source, replicating 1-bit sources.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        src[i]    <= '0;
        aloc_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        aloc_d[i] <= aloc[i];
        unique case (asel[i])
          SEL_CONST: src[i] <= C[i*W +: W];
          SEL_PWM:   src[i] <= {W{pwb[i]}};
          SEL_CLOCK: src[i] <= {W{ckb[i]}};
          SEL_INPUT: src[i] <= IN[i*W +: W];
        endcase
      end
    end
  end

  // Route stage: output j takes source aloc_d[j]; out-of-range index gives 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT <= '0;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (int'(aloc_d[j]) < NCH) begin
          OUT[j*W +: W] <= src[aloc_d[j]];
        end else begin
          OUT[j*W +: W] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_signal_router_param.sv
// Testbench for signal_router_param: stimulus pushes expected values tagged
// with the cycle they are due; a monitor compares them on the falling edge.
module tb_signal_router_param;

  localparam int NCH  = 8;
  localparam int W    = 8;
  localparam int DIVW = 26;
  localparam int PWMW = 8;
  localparam int LW   = 3;
  localparam int N6   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NCH*W-1:0]    in_v, c_v, out_v;
  logic [NCH*DIVW-1:0] div_v;
  logic [NCH*PWMW-1:0] duty_v;
  logic [NCH*2-1:0]    rsel_v;
  logic [NCH*LW-1:0]   rloc_v;
  logic                cfg_load, cfg_ack;

  logic [N6*W-1:0]     in6, c6, out6;
  logic [N6*DIVW-1:0]  div6;
  logic [N6*PWMW-1:0]  duty6;
  logic [N6*2-1:0]     rsel6;
  logic [N6*3-1:0]     rloc6;
  logic                load6, ack6;

  signal_router_param dut (
    .CLK(clk), .RST(rst), .IN(in_v), .C(c_v), .DIV(div_v), .DUTY(duty_v),
    .RSEL(rsel_v), .RLOC(rloc_v), .CFG_LOAD(cfg_load), .CFG_ACK(cfg_ack),
    .OUT(out_v)
  );

  signal_router_param #(.NCH(N6)) dut6 (
    .CLK(clk), .RST(rst), .IN(in6), .C(c6), .DIV(div6), .DUTY(duty6),
    .RSEL(rsel6), .RLOC(rloc6), .CFG_LOAD(load6), .CFG_ACK(ack6),
    .OUT(out6)
  );

  typedef struct {
    int         cyc;
    int         kind;  // 0 OUT, 1 CFG_ACK, 2 OUT of dut6, 3 CFG_ACK of dut6
    int         idx;
    logic [7:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int idx, input int at,
                       input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] cycle %0d: got %02h, expected %02h",
                  name, idx, at, act, exp);
  endtask

  // Insert keeping the scoreboard ordered by due cycle.
  task automatic expect_v(input int c, input int kind, input int idx,
                          input logic [7:0] v);
    exp_t e;
    int   pos;
    e.cyc = c; e.kind = kind; e.idx = idx; e.v = v;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > c) pos--;
    sb.insert(pos, e);
  endtask

  // Monitor: compare every entry due in the current cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    string      nm;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        0:       begin act = out_v[e.idx*W +: W]; nm = "out";  end
        1:       begin act = {7'b0, cfg_ack};     nm = "ack";  end
        2:       begin act = out6[e.idx*W +: W];  nm = "out6"; end
        default: begin act = {7'b0, ack6};        nm = "ack6"; end
      endcase
      if (e.cyc < cyc) begin
        n_total++;
        $display("FAIL %s[%0d] missed cycle %0d (now %0d)", nm, e.idx, e.cyc, cyc);
      end else begin
        check(nm, e.idx, cyc, act, e.v);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic set_ch(input int i, input logic [1:0] sel, input int dv, input int dt);
    rsel_v[i*2 +: 2]       = sel;
    div_v[i*DIVW +: DIVW]  = DIVW'(dv);
    duty_v[i*PWMW +: PWMW] = PWMW'(dt);
  endtask

  task automatic set_loc(input int j, input int l);
    rloc_v[j*LW +: LW] = LW'(l);
  endtask

  task automatic commit(output int k);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    k = cyc;
    expect_v(k, 1, 0, 8'h01);
    expect_v(k + 1, 1, 0, 8'h00);
  endtask

  function automatic logic [7:0] clk_exp(input int n);
    return (((n - 2) / 3) % 2 == 1) ? 8'hFF : 8'h00;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, k2, m, r, guard;
    rst = 1'b1; cfg_load = 1'b0; load6 = 1'b0;
    in_v = '0; c_v = '0; div_v = '0; duty_v = '0; rsel_v = '0; rloc_v = '0;
    in6 = '0; c6 = '0; div6 = '0; duty6 = '0; rsel6 = '0; rloc6 = '0;

    // Reset state
    step(); step();
    expect_v(cyc, 1, 0, 8'h00);
    for (int j = 0; j < NCH; j++) expect_v(cyc, 0, j, 8'h00);
    expect_v(cyc, 2, 0, 8'h00);
    rst = 1'b0;
    step(); step(); step();

    // Static route: out0 <- ch3, others <- ch0; old routing holds one more cycle
    c_v[0*W +: W] = 8'hA5;
    c_v[3*W +: W] = 8'h3C;
    set_loc(0, 3);
    commit(k);
    expect_v(k + 1, 0, 0, 8'hA5);
    expect_v(k + 2, 0, 0, 8'h3C);
    for (int j = 1; j < NCH; j++) expect_v(k + 2, 0, j, 8'hA5);
    wait_until(k + 2);

    // Clock source: ch2 divided by 3, routed to out5
    set_ch(2, 2'b10, 3, 0);
    set_loc(5, 2);
    commit(k);
    for (int n = 2; n <= 20; n++) expect_v(k + n, 0, 5, clk_exp(n));
    wait_until(k + 26);
    // Load on the tick edge k+27: ckb restarts at 0 instead of toggling to 1
    commit(k2);
    for (int n = 2; n <= 14; n++) expect_v(k2 + n, 0, 5, clk_exp(n));
    wait_until(k2 + 14);

    // PWM: ch1, tick every cycle, duty 64 -> high for cycles 3..66, period 256
    set_ch(1, 2'b01, 1, 64);
    set_loc(6, 1);
    commit(k);
    for (int n = 3; n <= 300; n++)
      expect_v(k + n, 0, 6, (((n - 3) % 256) < 64) ? 8'hFF : 8'h00);
    wait_until(k + 300);
    set_ch(1, 2'b01, 1, 0);
    commit(k);
    for (int n = 3; n <= 60; n++) expect_v(k + n, 0, 6, 8'h00);
    wait_until(k + 60);

    // Input path with fan-out to every output
    set_ch(4, 2'b11, 0, 0);
    in_v[4*W +: W] = 8'h11;
    for (int j = 0; j < NCH; j++) set_loc(j, 4);
    commit(k);
    for (int j = 0; j < NCH; j++) expect_v(k + 2, 0, j, 8'h11);
    wait_until(k + 4);
    in_v[4*W +: W] = 8'h22;
    m = cyc;
    for (int j = 0; j < NCH; j++) begin
      expect_v(m + 1, 0, j, 8'h11);
      expect_v(m + 2, 0, j, 8'h22);
    end
    wait_until(m + 2);

    // DIV=0: clock source stays low
    set_ch(2, 2'b10, 0, 0);
    set_loc(5, 2);
    commit(k);
    for (int n = 2; n <= 60; n++) expect_v(k + n, 0, 5, 8'h00);
    wait_until(k + 60);

    // Back-to-back loads keep CFG_ACK high
    k = cyc + 1;
    expect_v(k, 1, 0, 8'h01);
    expect_v(k + 1, 1, 0, 8'h01);
    expect_v(k + 2, 1, 0, 8'h00);
    cfg_load = 1'b1;
    step(); step();
    cfg_load = 1'b0;
    wait_until(k + 2);

    // NCH=6: route indices 6 and 7 are out of range and give 0
    c6[0*W +: W] = 8'h5A;
    c6[5*W +: W] = 8'h77;
    rloc6[0*3 +: 3] = 3'd7;
    rloc6[2*3 +: 3] = 3'd5;
    rloc6[3*3 +: 3] = 3'd6;
    load6 = 1'b1;
    step();
    load6 = 1'b0;
    k = cyc;
    expect_v(k, 3, 0, 8'h01);
    expect_v(k + 1, 2, 0, 8'h5A);
    expect_v(k + 2, 2, 0, 8'h00);
    expect_v(k + 2, 2, 1, 8'h5A);
    expect_v(k + 2, 2, 2, 8'h77);
    expect_v(k + 2, 2, 3, 8'h00);
    wait_until(k + 2);

    // Reset mid-run with PWM active, a pending ACK and a coincident load
    c_v[0*W +: W] = 8'h5E;
    for (int j = 0; j < NCH; j++) set_loc(j, 0);
    set_loc(6, 1);
    set_ch(0, 2'b00, 0, 0);
    set_ch(1, 2'b01, 1, 64);
    commit(k);
    wait_until(k + 5);
    expect_v(k + 6, 1, 0, 8'h01);
    expect_v(k + 6, 0, 6, 8'hFF);
    cfg_load = 1'b1;
    step();
    rst = 1'b1;
    set_ch(0, 2'b11, 0, 0);
    in_v[0*W +: W] = 8'h99;
    r = cyc + 1;
    expect_v(r, 1, 0, 8'h00);
    expect_v(r + 1, 1, 0, 8'h00);
    for (int j = 0; j < NCH; j++) begin
      expect_v(r, 0, j, 8'h00);
      expect_v(r + 1, 0, j, 8'h00);
      expect_v(r + 2, 0, j, 8'h5E);
    end
    step();
    rst = 1'b0;
    cfg_load = 1'b0;
    wait_until(r + 2);

    // Drain the scoreboard
    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      step();
      guard++;
    end
    check("drain", 0, cyc, 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/signal_router_param.md
# signal_router_param

Parametrised successor to the fixed 8-channel signal router. Each of `NCH` channels picks one source: a constant, its own PWM generator, its own divided clock, or its external input. A routing crossbar then maps any channel's source onto any output. All dividers and PWMs run as clock enables in the single `CLK` domain, with no derived clocks. Configuration is double-buffered and committed atomically by a load strobe with acknowledge; the block sits between the register file and the I/O pin mux.

## Interface
Parameters:
- `NCH`, 8: channel count (≥2).
- `W`, 8: data width per channel.
- `DIVW`, 26: clock-divider word width.
- `PWMW`, 8: PWM duty/counter width.
- `LW`, localparam = clog2(`NCH`): routing index width per output.

Ports:
- `CLK`  in  1: single clock, all logic on rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `IN`  in  NCH*W: external inputs, channel i at [i*W +: W].
- `C`  in  NCH*W: constant values, channel i at [i*W +: W].
- `DIV`  in  NCH*DIVW: shadow divider value per channel.
- `DUTY`  in  NCH*PWMW: shadow PWM duty per channel.
- `RSEL`  in  NCH*2: shadow source select (00 const, 01 PWM, 10 clock, 11 input).
- `RLOC`  in  NCH*LW: shadow route index; output j takes source RLOC[j*LW +: LW].
- `CFG_LOAD`  in  1: commit strobe for the shadow config.
- `CFG_ACK`  out  1: one-cycle pulse confirming commit.
- `OUT`  out  NCH*W: routed outputs, output j at [j*W +: W].

## Operation
- Active config registers (`asel`, `aloc`, `adiv`, `aduty`) drive all logic. Shadow ports have no effect until committed.
- Commit: when `CFG_LOAD`=1 at a rising edge and `RST`=0:
  - Copy all shadow ports into the active registers.
  - Clear every divider counter, clock bit and PWM counter.
  - Assert `CFG_ACK` for the following cycle only.
  - Back-to-back loads are all accepted; `CFG_ACK` stays high while they continue.
- Divider, channel i: counter `dcnt` counts 0..adiv-1.
  - At `dcnt`==adiv-1: wrap to 0, toggle `ckb[i]`, emit one-cycle `tick[i]`.
  - adiv=0: counter, `ckb` and tick held at 0.
  - adiv=1: toggles every cycle.
  - Clock period is 2*adiv cycles.
- PWM, channel i: `pcnt` (PWMW bits) increments on `tick[i]` and wraps 2^PWMW-1 -> 0. `pwb[i]` = (pcnt < aduty), registered.
  - duty 0: constant low.
  - duty 2^PWMW-1: low for 1 of 2^PWMW tick periods.
- Source stage (registered): `src[i]` =
  - `C[i]` when sel 00;
  - {W{pwb[i]}} when sel 01;
  - {W{ckb[i]}} when sel 10;
  - `IN[i]` when sel 11.
  - 1-bit sources are replicated across all W bits.
- Route stage (registered): `OUT[j]` = src[aloc[j]]. If aloc[j] ≥ NCH (NCH not a power of two), `OUT[j]`=0.
- One source may fan out to several outputs. Unselected sources keep running.

## Timing
- Reset values:
  - `OUT`=0 and `CFG_ACK`=0.
  - All active config 0, which means sel const, loc 0, div 0, duty 0.
  - All counters, `ckb` and `pwb` 0.
- `RST` wins over `CFG_LOAD` in the same cycle. The load is dropped and no ACK is issued.
- `RST` asserted mid-operation clears everything at that edge. A pending ACK is cancelled.
- `IN`/`C` to `OUT` latency is 2 cycles: source register, then route register.
- `ckb`/`pwb` change to `OUT` latency is 2 cycles.
- Commit at edge k:
  - New sel/loc are visible at `OUT` after edge k+2. Until then the previous routing stays.
  - `CFG_ACK` is high from edge k to edge k+1.
- After commit, the first divider tick occurs at edge k+adiv, counting the commit edge as k.
- `CFG_LOAD` coinciding with a tick: the load wins. Counters clear and the tick has no effect on `pcnt`.
- Divider arithmetic is unsigned DIVW-bit. The compare uses adiv-1 only when adiv≠0, so there is no underflow.

## Test plan
- Reset then static route: C[0]=0xA5, C[3]=0x3C, sel all 00, RLOC out0=3, out1=0, pulse CFG_LOAD -> CFG_ACK high 1 cycle; OUT1=0xA5 and OUT0=0x3C two cycles after commit; all other outputs 0xA5 (loc 0).
- Clock source: ch2 sel 10, DIV=3, out5 routed to 2 -> OUT5 toggles 0x00/0xFF every 3 cycles, period 6; first toggle at commit+3, visible at OUT at commit+5.
- PWM: ch1 sel 01, DIV=1, DUTY=64 -> OUT high (0xFF) exactly 64 of every 256 cycles; DUTY=0 -> always 0x00.
- Input path and fan-out: ch4 sel 11, all outputs loc 4, IN[4] stepped 0x11->0x22 -> every OUT follows with 2-cycle latency.
- Boundaries:
  - DIV=0 -> clock source stays 0 indefinitely.
  - NCH=6 (LW=3) with loc=7 -> that OUT=0.
  - CFG_LOAD on the same edge as a tick -> counters restart and the next tick falls at +DIV.
- Reset mid-run: assert RST for 1 cycle while PWM is active and CFG_LOAD=1 -> OUT=0 and CFG_ACK=0 next cycle, config back to defaults, load discarded.
